// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Main register drives the EX side; skid absorbs one word when EX stalls,
// so in_ready is decoded straight from the state flop.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned MEM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB_ctl_in,
  input  logic [MEM_W-1:0]  MEM_ctl_in,
  input  logic [3:0]        EX_ctl_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] immed_exted_in,
  input  logic [REG_W-1:0]  Rt_in,
  input  logic [REG_W-1:0]  Rd_in,
  input  logic [REG_W-1:0]  shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WB_ctl_out,
  output logic [MEM_W-1:0]  MEM_ctl_out,
  output logic              RegDst,
  output logic              ALUsrc,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] RD1_out,
  output logic [DATA_W-1:0] RD2_out,
  output logic [DATA_W-1:0] immed_exted_out,
  output logic [REG_W-1:0]  Rt_out,
  output logic [REG_W-1:0]  Rd_out,
  output logic [REG_W-1:0]  shamt_out
);

  localparam int unsigned PW = WB_W + MEM_W + 4 + 4 * DATA_W + 3 * REG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_word;
  logic            accept, drain;
  logic [WB_W-1:0] wb_q;
  logic [MEM_W-1:0] mem_q;
  logic [3:0]      ex_q;

  assign in_word = {WB_ctl_in, MEM_ctl_in, EX_ctl_in, pc_in, RD1_in, RD2_in,
                    immed_exted_in, Rt_in, Rd_in, shamt};

  assign {wb_q, mem_q, ex_q, pc_out, RD1_out, RD2_out, immed_exted_out,
          Rt_out, Rd_out, shamt_out} = main_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Control fields read zero whenever no instruction is presented to EX
  assign WB_ctl_out  = out_valid ? wb_q  : '0;
  assign MEM_ctl_out = out_valid ? mem_q : '0;
  assign RegDst      = out_valid & ex_q[3];
  assign ALUop       = out_valid ? ex_q[2:1] : '0;
  assign ALUsrc      = out_valid & ex_q[0];

  // Next-state and payload steering; flush overrides every other event
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_word;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_d = in_word;
          end else if (accept) begin
            skid_d  = in_word;
            state_d = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers, cleared asynchronously by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_ex_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [3:0]  mem;
    logic [3:0]  ex;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  WB_ctl_in, WB_ctl_out;
  logic [3:0]  MEM_ctl_in, MEM_ctl_out, EX_ctl_in;
  logic [31:0] pc_in, RD1_in, RD2_in, immed_exted_in;
  logic [31:0] pc_out, RD1_out, RD2_out, immed_exted_out;
  logic [4:0]  Rt_in, Rd_in, shamt, Rt_out, Rd_out, shamt_out;
  logic        RegDst, ALUsrc;
  logic [1:0]  ALUop;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_ctl_in(WB_ctl_in), .MEM_ctl_in(MEM_ctl_in), .EX_ctl_in(EX_ctl_in),
    .pc_in(pc_in), .RD1_in(RD1_in), .RD2_in(RD2_in),
    .immed_exted_in(immed_exted_in),
    .Rt_in(Rt_in), .Rd_in(Rd_in), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_ctl_out(WB_ctl_out), .MEM_ctl_out(MEM_ctl_out),
    .RegDst(RegDst), .ALUsrc(ALUsrc), .ALUop(ALUop),
    .pc_out(pc_out), .RD1_out(RD1_out), .RD2_out(RD2_out),
    .immed_exted_out(immed_exted_out),
    .Rt_out(Rt_out), .Rd_out(Rd_out), .shamt_out(shamt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t make(input logic [31:0] pc, input logic [3:0] ex);
    word_t w;
    w.wb  = pc[3:2];
    w.mem = pc[5:2] ^ 4'h9;
    w.ex  = ex;
    w.pc  = pc;
    w.rd1 = pc ^ 32'hA5A5_0000;
    w.rd2 = ~pc;
    w.imm = pc + 32'h100;
    w.rt  = pc[4:0] ^ 5'h3;
    w.rd  = pc[6:2];
    w.sh  = pc[9:5] + 5'd1;
    return w;
  endfunction

  // Reference model: FIFO of at most two accepted words
  word_t q[$];
  word_t held = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      held = '0;
    end else begin
      automatic logic  acc = in_valid && (q.size() < 2);
      automatic logic  drn = (q.size() > 0) && out_ready;
      automatic word_t w;
      w = {WB_ctl_in, MEM_ctl_in, EX_ctl_in, pc_in, RD1_in, RD2_in,
           immed_exted_in, Rt_in, Rd_in, shamt};
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(w);
      end
      if (q.size() > 0) held = q[0];
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    automatic logic       ev = (q.size() > 0);
    automatic logic [9:0] ectl = ev ? {q[0].wb, q[0].mem, q[0].ex} : 10'd0;
    chk("out_valid", {159'd0, out_valid}, {159'd0, ev});
    chk("in_ready", {159'd0, in_ready}, {159'd0, (q.size() < 2)});
    chk("ctl", {150'd0, WB_ctl_out, MEM_ctl_out, RegDst, ALUop, ALUsrc},
        {150'd0, ectl});
    chk("data", {17'd0, pc_out, RD1_out, RD2_out, immed_exted_out,
                 Rt_out, Rd_out, shamt_out},
        {17'd0, held.pc, held.rd1, held.rd2, held.imm, held.rt, held.rd,
         held.sh});
  end

  task automatic step(input logic v, input logic f, input logic r,
                      input word_t w);
    in_valid = v;
    flush = f;
    out_ready = r;
    {WB_ctl_in, MEM_ctl_in, EX_ctl_in, pc_in, RD1_in, RD2_in,
     immed_exted_in, Rt_in, Rd_in, shamt} = w;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
           make($urandom, 4'($urandom)));
    chk("rst_out_valid", {159'd0, out_valid}, 160'd0);
    chk("rst_in_ready", {159'd0, in_ready}, 160'd1);
    chk("rst_pc_out", {128'd0, pc_out}, 160'd0);
    chk("rst_ctl", {150'd0, WB_ctl_out, MEM_ctl_out, RegDst, ALUop, ALUsrc},
        160'd0);

    // First accept right after release
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, make(32'h40, 4'b1011));
    chk("first_pc", {128'd0, pc_out}, 160'h40);
    chk("first_ex", {156'd0, RegDst, ALUop, ALUsrc}, 160'hB);
    chk("first_valid", {159'd0, out_valid}, 160'd1);

    // Streaming, one per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, make(32'(i * 4), 4'(i)));
      chk("stream_pc", {128'd0, pc_out}, 160'(i * 4));
      chk("stream_valid", {159'd0, out_valid}, 160'd1);
    end
    step(1'b0, 1'b0, 1'b1, '0);

    // Backpressure: three offered, two captured
    step(1'b1, 1'b0, 1'b0, make(32'h100, 4'h1));
    step(1'b1, 1'b0, 1'b0, make(32'h104, 4'h2));
    chk("bp_full_ready", {159'd0, in_ready}, 160'd0);
    step(1'b1, 1'b0, 1'b0, make(32'h108, 4'h3));
    chk("bp_hold_pc", {128'd0, pc_out}, 160'h100);
    step(1'b1, 1'b0, 1'b1, make(32'h108, 4'h3));
    chk("bp_drain1_pc", {128'd0, pc_out}, 160'h104);
    chk("bp_drain1_ready", {159'd0, in_ready}, 160'd1);
    step(1'b1, 1'b0, 1'b1, make(32'h108, 4'h3));
    chk("bp_third_pc", {128'd0, pc_out}, 160'h108);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("bp_empty_valid", {159'd0, out_valid}, 160'd0);
    chk("bp_payload_kept", {128'd0, pc_out}, 160'h108);

    // Flush from FULL with a concurrent offer
    step(1'b1, 1'b0, 1'b0, make(32'h200, 4'hF));
    step(1'b1, 1'b0, 1'b0, make(32'h204, 4'hF));
    step(1'b1, 1'b1, 1'b0, make(32'h208, 4'hF));
    chk("fl_valid", {159'd0, out_valid}, 160'd0);
    chk("fl_ready", {159'd0, in_ready}, 160'd1);
    chk("fl_ctl", {150'd0, WB_ctl_out, MEM_ctl_out, RegDst, ALUop, ALUsrc},
        160'd0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("fl_no_ghost", {159'd0, out_valid}, 160'd0);

    // Asynchronous reset while FULL, between clock edges
    step(1'b1, 1'b0, 1'b0, make(32'h300, 4'hF));
    step(1'b1, 1'b0, 1'b0, make(32'h304, 4'hF));
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {159'd0, out_valid}, 160'd0);
    chk("arst_ready", {159'd0, in_ready}, 160'd1);
    chk("arst_pc", {128'd0, pc_out}, 160'd0);
    chk("arst_wb", {158'd0, WB_ctl_out}, 160'd0);
    @(negedge clk);
    rst = 1'b1;

    // Random valid/ready/flush against the model
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(3) != 0), ($urandom_range(15) == 0),
           1'($urandom_range(1)), make($urandom, 4'($urandom)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline stage for the MIPS pipeline. It carries decoded control and operand payload from ID to EX with a valid/ready handshake, which gives the ID/EX boundary backpressure that a plain clocked register lacks. A 2-entry skid buffer keeps `in_ready` a registered signal, so there is no combinational ready path back into ID. It also inserts bubbles on flush and zeroes the WB/MEM control outputs whenever no valid instruction is presented, so hazard logic can squash or stall at this boundary.

## Interface
- `DATA_W`, 32, width of pc, RD1, RD2 and immediate
- `REG_W`, 5, width of Rt, Rd and shamt
- `WB_W`, 2, width of WB control field
- `MEM_W`, 4, width of MEM control field
- Clock and reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  ID presents an instruction
- `in_ready`  out  1  stage can accept; equals NOT skid_valid
- `WB_ctl_in`  in  WB_W  WB control
- `MEM_ctl_in`  in  MEM_W  MEM control
- `EX_ctl_in`  in  4  {RegDst, ALUop[1:0], ALUsrc}
- `pc_in`, `RD1_in`, `RD2_in`, `immed_exted_in`  in  DATA_W each  operand payload
- `Rt_in`, `Rd_in`, `shamt`  in  REG_W each  register indices and shift amount
- `out_valid`  out  1  EX-side instruction valid
- `out_ready`  in  1  EX accepts this cycle
- `WB_ctl_out`  out  WB_W  WB control, forced 0 when `out_valid`=0
- `MEM_ctl_out`  out  MEM_W  MEM control, forced 0 when `out_valid`=0
- `RegDst`, `ALUsrc`  out  1 each  from EX_ctl bits 3 and 0
- `ALUop`  out  2  from EX_ctl bits 2:1
- `pc_out`, `RD1_out`, `RD2_out`, `immed_exted_out`  out  DATA_W each  payload
- `Rt_out`, `Rd_out`, `shamt_out`  out  REG_W each  payload

## Operation
- Storage is a main register (drives outputs) plus a skid register, each with a valid bit.
- Accept: `in_valid & in_ready`. Drain: `out_valid & out_ready`.
- States and transitions:
  - EMPTY (main=0, skid=0): accept -> BUSY.
  - BUSY (main=1, skid=0):
    - accept & drain -> BUSY, new word loaded into main.
    - accept & no drain -> FULL, new word captured in skid.
    - drain only -> EMPTY.
    - neither -> BUSY, hold.
  - FULL (main=1, skid=1): `in_ready`=0. Drain -> BUSY, skid moves to main and skid clears. No drain -> hold.
- Flush has priority over every other event. Next state is EMPTY; an accept in the same cycle is discarded; a drain in the same cycle still completes on the EX side.
- Payload registers do not change on flush or drain-to-empty; only valid bits clear.
- Gating: when `out_valid`=0, `WB_ctl_out`, `MEM_ctl_out`, `RegDst`, `ALUsrc` and `ALUop` read 0. Data payload outputs are not gated.
- Ordering is strict FIFO. An instruction is never duplicated or dropped, except by flush.

## Timing
- Latency: accept at edge N -> `out_valid`=1 after edge N, so visible in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1; the skid stays empty.
- `in_ready` comes from a flop with no combinational path from `out_ready`. A deassertion of `out_ready` costs at most one extra buffered word.
- Reset (`rst`=0, asynchronous): both valid bits 0; every output 0 except `in_ready`=1.
- On `rst` release, the first accept is possible at the first rising edge.
- Reset asserted mid-operation: all held entries are lost immediately, without waiting for a clock edge.
- `flush` and `out_ready`=0 while FULL: the stage goes to EMPTY and `in_ready`=1 next cycle.

## Test plan
- Reset: hold `rst`=0 with random inputs -> all outputs 0, `in_ready`=1. After release, inputs pc=0x40 and EX_ctl=4'b1011 -> next cycle `pc_out`=0x40, RegDst=1, ALUop=01, ALUsrc=1, `out_valid`=1.
- Streaming: 8 back-to-back instructions with pc 0x00..0x1C and `out_ready`=1 -> out 1 cycle later, in order, with no gaps.
- Backpressure: `out_ready`=0 while 3 instructions are offered -> 2 captured, `in_ready`=0 after the second. `out_ready`=1 -> first two drain in order and the third is accepted; nothing is lost.
- Flush from FULL: `flush`=1 with `in_valid`=1 -> next cycle `out_valid`=0, WB/MEM/ALU control 0, `in_ready`=1, and the flushed-cycle input never appears.
- Asynchronous reset mid-stream: drop `rst` between clock edges while in FULL -> outputs 0 immediately, with no clock edge required.
- Random valid/ready/flush (10k cycles) against a reference queue model -> order, payload and control gating all match.
